tdd_sync_gen: RTL and testbench
===============================

Name: tdd_sync_gen

Overview:
- Generates the TDD synchronisation pulse that feeds the AD9361 core's tdd_sync_i input in the zed PL design.
- Modes: free-running periodic, one-shot, or re-timed from an external board-level sync.
- Sits between the PL register/control path and the transceiver wrapper.
- Also drives the tristate sync pad, which lets one board act as sync master for others.

Parameters:
- PERIOD_WIDTH, 32, width of the period counter and period input.
- PULSE_WIDTH_BITS, 16, width of the pulse-width counter and input.
- CNT_WIDTH, 16, width of the pulse counter status output.
- SYNC_STAGES, 2, number of synchroniser flops on ext_sync_in (minimum 2).

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_areset  in  1  asynchronous, active-high reset.
- enable  in  1  level; generator runs while high.
- mode  in  2  0=continuous, 1=one-shot, 2=external, 3=reserved (treated as disabled).
- arm  in  1  single-cycle strobe; starts one pulse in mode 1.
- period  in  PERIOD_WIDTH  cycles between sync_out rising edges.
- pulse_width  in  PULSE_WIDTH_BITS  high time of sync_out, in cycles.
- ext_sync_in  in  1  asynchronous external sync, rising-edge sensitive.
- sync_out  out  1  registered pulse; connects to tdd_sync_i.
- sync_pad_o  out  1  equals sync_out.
- sync_pad_t  out  1  pad tristate: 0 drive, 1 hi-Z.
- busy  out  1  high when the FSM is not IDLE.
- cfg_err  out  1  sticky; set on a rejected configuration.
- ext_overrun  out  1  sticky; set when an ext edge arrives while a pulse is in progress.
- pulse_cnt  out  CNT_WIDTH  number of pulses emitted; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, sync deassert):
  - all outputs 0 except sync_pad_t=1.
  - FSM to IDLE; counters 0; synchroniser flops 0.
- Configuration sampling:
  - period and pulse_width are latched on every IDLE->PULSE or IDLE->ARMED transition.
  - changes while busy take effect only at the next start.
- Validation at start:
  - pulse_width==0 is rejected.
  - period<=pulse_width is rejected in mode 0 only.
  - On reject: cfg_err<=1, stay IDLE, no pulse.
  - cfg_err clears only when enable goes low.
- sync_pad_t = ~(enable & mode!=3 & mode!=2). In external mode the pad is an input, so it stays hi-Z.
- ext path:
  - SYNC_STAGES-flop synchroniser, then a registered rising-edge detect giving ext_edge.
  - Latency from an ext_sync_in rising edge to ext_edge is SYNC_STAGES+1 cycles.
- FSM states: IDLE, ARMED, PULSE, GAP.
  - IDLE -> PULSE:
    - mode 0: enable high.
    - mode 1: enable & arm.
    - sync_out goes high on the cycle after the trigger is sampled.
  - IDLE -> ARMED: mode 2 & enable.
  - ARMED -> PULSE: on ext_edge. sync_out goes high on the next cycle.
  - PULSE:
    - sync_out=1 for exactly pulse_width cycles.
    - pulse_cnt increments on the first PULSE cycle.
    - Exit on the last cycle:
      - mode 0 -> GAP.
      - mode 1 -> IDLE.
      - mode 2 -> ARMED.
  - GAP (mode 0 only):
    - sync_out=0 for period-pulse_width cycles, then -> PULSE.
    - Rising-edge spacing is therefore exactly period cycles.
  - ext_edge in PULSE, GAP or IDLE: ignored, and ext_overrun<=1 if busy.
- Disable / mode change:
  - enable low or mode changed during PULSE: the current pulse completes its full width, then -> IDLE. No truncated pulses.
  - enable low during GAP or ARMED: -> IDLE next cycle.
- arm while busy is ignored.
- arm and enable rising in the same cycle in mode 1 is a valid start.
- busy = (state != IDLE), registered.
- Counter widths: the period counter is PERIOD_WIDTH bits and never wraps, because the terminal compare is exact.

Test Plan:
1. Reset mid-pulse: mode 0, period=10, pulse_width=3, assert axi_areset during PULSE -> sync_out=0, busy=0, pulse_cnt=0, sync_pad_t=1 immediately (async).
2. Continuous mode: enable=1, mode=0, period=10, pulse_width=3 -> sync_out high one cycle after enable, high for 3 cycles, rising edges every 10 cycles; pulse_cnt=5 after 50 cycles.
3. One-shot: mode=1, pulse_width=4, arm strobe -> exactly one 4-cycle pulse, pulse_cnt=1, busy falls after it; a second arm during the pulse produces nothing extra.
4. External mode: mode=2, pulse_width=2, ext_sync_in rising -> sync_out high SYNC_STAGES+2 cycles later (4 with the default); a second ext edge arriving during the pulse -> ext_overrun=1 and no extra pulse.
5. Bad config: mode=0, period=3, pulse_width=3 -> cfg_err=1, sync_out stays 0; drop enable -> cfg_err=0.
6. Disable mid-pulse: mode 0, pulse_width=5, drop enable on the 2nd high cycle -> pulse still lasts 5 cycles, then IDLE, no further edges; pulse_cnt wraps 0xFFFF->0x0000 when preloaded via a long run.

Source files
------------

// File: rtl/tdd_sync_gen.sv
// TDD sync pulse generator for the AD9361 tdd_sync_i input: continuous, one-shot or
// re-timed from an external board sync, with pad tristate control for sync-master boards.
module tdd_sync_gen #(
  parameter int unsigned PERIOD_WIDTH     = 32,
  parameter int unsigned PULSE_WIDTH_BITS = 16,
  parameter int unsigned CNT_WIDTH        = 16,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic                        arm,
  input  logic [PERIOD_WIDTH-1:0]     period,
  input  logic [PULSE_WIDTH_BITS-1:0] pulse_width,
  input  logic                        ext_sync_in,
  output logic                        sync_out,
  output logic                        sync_pad_o,
  output logic                        sync_pad_t,
  output logic                        busy,
  output logic                        cfg_err,
  output logic                        ext_overrun,
  output logic [CNT_WIDTH-1:0]        pulse_cnt
);

  typedef enum logic [1:0] {StIdle, StArmed, StPulse, StGap} state_e;

  localparam logic [1:0] ModeCont    = 2'd0;
  localparam logic [1:0] ModeOneShot = 2'd1;
  localparam logic [1:0] ModeExt     = 2'd2;
  localparam int unsigned CmpW = (PERIOD_WIDTH > PULSE_WIDTH_BITS) ? PERIOD_WIDTH
                                                                    : PULSE_WIDTH_BITS;

  state_e                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      sync_q, sync_d;
  logic                        ext_prev_q, ext_prev_d;
  logic                        ext_edge_q, ext_edge_d;
  logic [PULSE_WIDTH_BITS-1:0] pw_q, pw_d;
  logic [PULSE_WIDTH_BITS-1:0] pw_cnt_q, pw_cnt_d;
  logic [PERIOD_WIDTH-1:0]     gap_len_q, gap_len_d;
  logic [PERIOD_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        sync_out_q, sync_out_d;
  logic                        pad_t_q, pad_t_d;
  logic                        busy_q, busy_d;
  logic                        cfg_err_q, cfg_err_d;
  logic                        overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]        pulse_cnt_q, pulse_cnt_d;

  logic pw_zero, period_short, leave;

  assign pw_zero      = (pulse_width == '0);
  assign period_short = (CmpW'(period) <= CmpW'(pulse_width));
  // Leaving the current run: enable dropped or mode changed since the start.
  assign leave        = ~enable | (mode != mode_q);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], ext_sync_in};
    ext_prev_d  = sync_q[SYNC_STAGES-1];
    ext_edge_d  = sync_q[SYNC_STAGES-1] & ~ext_prev_q;

    state_d     = state_q;
    pw_d        = pw_q;
    pw_cnt_d    = pw_cnt_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    mode_d      = mode_q;
    pulse_cnt_d = pulse_cnt_q;
    cfg_err_d   = enable ? cfg_err_q : 1'b0;
    overrun_d   = overrun_q | (ext_edge_q & ((state_q == StPulse) | (state_q == StGap)));

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          unique case (mode)
            ModeCont: begin
              if (pw_zero || period_short) begin
                cfg_err_d = 1'b1;
              end else begin
                state_d = StPulse;
              end
            end
            ModeOneShot: begin
              if (arm) begin
                if (pw_zero) cfg_err_d = 1'b1;
                else         state_d   = StPulse;
              end
            end
            ModeExt: begin
              if (pw_zero) cfg_err_d = 1'b1;
              else         state_d   = StArmed;
            end
            default: ;
          endcase
          if (state_d != StIdle) begin
            pw_d      = pulse_width;
            gap_len_d = PERIOD_WIDTH'(CmpW'(period) - CmpW'(pulse_width));
            mode_d    = mode;
          end
        end
      end
      StArmed: begin
        if (leave)           state_d = StIdle;
        else if (ext_edge_q) state_d = StPulse;
      end
      StPulse: begin
        if (pw_cnt_q == pw_q) begin
          if (leave) begin
            state_d = StIdle;
          end else begin
            unique case (mode_q)
              ModeCont: begin
                state_d   = StGap;
                gap_cnt_d = PERIOD_WIDTH'(1);
              end
              ModeExt: state_d = StArmed;
              default: state_d = StIdle;
            endcase
          end
        end else begin
          pw_cnt_d = pw_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (leave)                        state_d   = StIdle;
        else if (gap_cnt_q == gap_len_q)  state_d   = StPulse;
        else                              gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Every entry into PULSE restarts the width count and bumps the pulse counter.
    if (state_d == StPulse && state_q != StPulse) begin
      pw_cnt_d    = PULSE_WIDTH_BITS'(1);
      pulse_cnt_d = pulse_cnt_q + 1'b1;
    end

    sync_out_d = (state_d == StPulse);
    busy_d     = (state_d != StIdle);
    pad_t_d    = ~(enable & ((mode == ModeCont) | (mode == ModeOneShot)));
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      ext_prev_q  <= 1'b0;
      ext_edge_q  <= 1'b0;
      pw_q        <= '0;
      pw_cnt_q    <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      mode_q      <= '0;
      sync_out_q  <= 1'b0;
      pad_t_q     <= 1'b1;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      ext_prev_q  <= ext_prev_d;
      ext_edge_q  <= ext_edge_d;
      pw_q        <= pw_d;
      pw_cnt_q    <= pw_cnt_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      mode_q      <= mode_d;
      sync_out_q  <= sync_out_d;
      pad_t_q     <= pad_t_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      overrun_q   <= overrun_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign sync_out    = sync_out_q;
  assign sync_pad_o  = sync_out_q;
  assign sync_pad_t  = pad_t_q;
  assign busy        = busy_q;
  assign cfg_err     = cfg_err_q;
  assign ext_overrun = overrun_q;
  assign pulse_cnt   = pulse_cnt_q;

endmodule

// File: tb/tb_tdd_sync_gen.sv
// Self-checking bench for tdd_sync_gen; expected sync_out per cycle is queued with the
// stimulus and popped as the DUT clocks. A narrow pulse counter keeps the wrap test short.
module tb_tdd_sync_gen;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [1:0]      mode;
  logic            arm;
  logic [31:0]     period;
  logic [15:0]     pulse_width;
  logic            ext_sync_in;
  logic            sync_out, sync_pad_o, sync_pad_t, busy, cfg_err, ext_overrun;
  logic [CntW-1:0] pulse_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  tdd_sync_gen #(
    .PERIOD_WIDTH    (32),
    .PULSE_WIDTH_BITS(16),
    .CNT_WIDTH       (CntW),
    .SYNC_STAGES     (2)
  ) dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .enable     (enable),
    .mode       (mode),
    .arm        (arm),
    .period     (period),
    .pulse_width(pulse_width),
    .ext_sync_in(ext_sync_in),
    .sync_out   (sync_out),
    .sync_pad_o (sync_pad_o),
    .sync_pad_t (sync_pad_t),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .ext_overrun(ext_overrun),
    .pulse_cnt  (pulse_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; mode = 2'd0; arm = 1'b0;
    period = '0; pulse_width = '0; ext_sync_in = 1'b0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({sync_out, sync_pad_t, busy, cfg_err, ext_overrun} !== 5'b01000 || pulse_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got so=%b pt=%b busy=%b err=%b ovr=%b cnt=%0d, expected 0 1 0 0 0 0",
               sync_out, sync_pad_t, busy, cfg_err, ext_overrun, pulse_cnt);
    end
    mode = 2'd0; period = 32'd10; pulse_width = 16'd3; enable = 1'b1;
    tick(); tick();
    tests_run++;
    if (sync_out !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_pulse: got so=%b busy=%b, expected 1 1", sync_out, busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({sync_out, sync_pad_o, sync_pad_t, busy} !== 4'b0010 || pulse_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got so=%b po=%b pt=%b busy=%b cnt=%0d, expected 0 0 1 0 0",
               sync_out, sync_pad_o, sync_pad_t, busy, pulse_cnt);
    end
    tick();
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_continuous();
    logic e;
    do_reset();
    mode = 2'd0; period = 32'd10; pulse_width = 16'd3; enable = 1'b1;
    for (int i = 0; i < 50; i++) exp_q.push_back((i % 10) < 3);
    for (int i = 0; i < 50; i++) begin
      tick();
      // Mid-run config change must not disturb the running pattern.
      if (i == 15) begin period = 32'd4; pulse_width = 16'd5; end
      e = exp_q.pop_front();
      tests_run++;
      if (sync_out !== e || sync_pad_o !== e) begin
        tests_failed++;
        $display("FAIL cont_sync[%0d]: got so=%b po=%b, expected %b", i, sync_out, sync_pad_o, e);
      end
    end
    tests_run++;
    if (pulse_cnt !== CntW'(5) || sync_pad_t !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL cont_status: got cnt=%0d pt=%b busy=%b, expected 5 0 1",
               pulse_cnt, sync_pad_t, busy);
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if ({sync_out, busy, sync_pad_t} !== 3'b001) begin
      tests_failed++;
      $display("FAIL cont_disable_gap: got so=%b busy=%b pt=%b, expected 0 0 1",
               sync_out, busy, sync_pad_t);
    end
  endtask

  task automatic test_one_shot();
    logic e;
    do_reset();
    mode = 2'd1; period = 32'd0; pulse_width = 16'd4; enable = 1'b1;
    tick(); tick();
    tests_run++;
    if (sync_out !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL oneshot_no_arm: got so=%b busy=%b, expected 0 0", sync_out, busy);
    end
    arm = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(i < 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) arm = 1'b0;
      if (i == 1) arm = 1'b1;
      if (i == 2) arm = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (sync_out !== e || busy !== e) begin
        tests_failed++;
        $display("FAIL oneshot[%0d]: got so=%b busy=%b, expected %b %b", i, sync_out, busy, e, e);
      end
    end
    tests_run++;
    if (pulse_cnt !== CntW'(1)) begin
      tests_failed++;
      $display("FAIL oneshot_cnt: got %0d, expected 1", pulse_cnt);
    end
  endtask

  task automatic test_external();
    logic e;
    do_reset();
    mode = 2'd2; period = 32'd0; pulse_width = 16'd2; enable = 1'b1;
    tick();
    tests_run++;
    if ({sync_out, busy, sync_pad_t} !== 3'b011) begin
      tests_failed++;
      $display("FAIL ext_armed: got so=%b busy=%b pt=%b, expected 0 1 1", sync_out, busy, sync_pad_t);
    end
    ext_sync_in = 1'b1;
    for (int i = 0; i < 12; i++) exp_q.push_back(i == 3 || i == 4);
    for (int i = 0; i < 12; i++) begin
      tick();
      // Second rising edge is timed to be detected while the pulse is running.
      if (i == 0) ext_sync_in = 1'b0;
      if (i == 1) ext_sync_in = 1'b1;
      e = exp_q.pop_front();
      tests_run++;
      if (sync_out !== e) begin
        tests_failed++;
        $display("FAIL ext_sync[%0d]: got %b, expected %b", i, sync_out, e);
      end
      if (i == 3) begin
        tests_run++;
        if (ext_overrun !== 1'b0) begin
          tests_failed++;
          $display("FAIL ext_overrun_early: got %b, expected 0", ext_overrun);
        end
      end
    end
    tests_run++;
    if (ext_overrun !== 1'b1 || pulse_cnt !== CntW'(1) || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ext_status: got ovr=%b cnt=%0d busy=%b, expected 1 1 1",
               ext_overrun, pulse_cnt, busy);
    end
  endtask

  task automatic test_bad_config();
    do_reset();
    mode = 2'd0; period = 32'd3; pulse_width = 16'd3; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if ({cfg_err, sync_out, busy} !== 3'b100) begin
        tests_failed++;
        $display("FAIL badcfg[%0d]: got err=%b so=%b busy=%b, expected 1 0 0",
                 i, cfg_err, sync_out, busy);
      end
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL badcfg_clear: got %b, expected 0", cfg_err);
    end
    mode = 2'd1; pulse_width = 16'd0; enable = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    tests_run++;
    if ({cfg_err, sync_out, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL badcfg_pw0: got err=%b so=%b busy=%b, expected 1 0 0", cfg_err, sync_out, busy);
    end
    enable = 1'b0;
    tick();
    // Period below width is legal outside continuous mode.
    mode = 2'd1; period = 32'd1; pulse_width = 16'd3; enable = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    tests_run++;
    if ({cfg_err, sync_out} !== 2'b01) begin
      tests_failed++;
      $display("FAIL badcfg_oneshot_ok: got err=%b so=%b, expected 0 1", cfg_err, sync_out);
    end
    mode = 2'd3; enable = 1'b1;
    repeat (4) tick();
    tests_run++;
    if ({busy, sync_out, sync_pad_t} !== 3'b001) begin
      tests_failed++;
      $display("FAIL mode3: got busy=%b so=%b pt=%b, expected 0 0 1", busy, sync_out, sync_pad_t);
    end
  endtask

  task automatic test_disable_mid_pulse();
    logic e;
    do_reset();
    mode = 2'd0; period = 32'd20; pulse_width = 16'd5; enable = 1'b1;
    for (int i = 0; i < 15; i++) exp_q.push_back(i < 5);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 1) enable = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (sync_out !== e || busy !== e) begin
        tests_failed++;
        $display("FAIL disable[%0d]: got so=%b busy=%b, expected %b %b", i, sync_out, busy, e, e);
      end
    end
    tests_run++;
    if (pulse_cnt !== CntW'(1)) begin
      tests_failed++;
      $display("FAIL disable_cnt: got %0d, expected 1", pulse_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    mode = 2'd0; period = 32'd2; pulse_width = 16'd1; enable = 1'b1;
    repeat (509) tick();
    tests_run++;
    if (pulse_cnt !== {CntW{1'b1}}) begin
      tests_failed++;
      $display("FAIL wrap_max: got %0d, expected %0d", pulse_cnt, (1 << CntW) - 1);
    end
    tick(); tick();
    tests_run++;
    if (pulse_cnt !== '0 || sync_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_zero: got cnt=%0d so=%b, expected 0 1", pulse_cnt, sync_out);
    end
    enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; arm = 1'b0;
    period = '0; pulse_width = '0; ext_sync_in = 1'b0;
    test_reset();
    test_continuous();
    test_one_shot();
    test_external();
    test_bad_config();
    test_disable_mid_pulse();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
